// File: rtl/ksa_seq_adder_pkg.sv
// Shared types for the sequential Kogge-Stone adder: FSM state encoding and
// the sizing rule for the chunk index counter.
package ksa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a one-bit index register.
    function automatic int idx_w(input int nwords);
        return (nwords <= 1) ? 1 : $clog2(nwords);
    endfunction

endpackage

// File: rtl/ksa_seq_adder_ksa.sv
// Single-cycle 2**wididx-bit Kogge-Stone adder with carry-in; reused once per
// chunk by the sequential adder.
module KSA #(
    parameter int wididx = 3
) (
    input  logic [(2**wididx)-1:0] i_a,
    input  logic [(2**wididx)-1:0] i_b,
    input  logic                   i_cin,
    output logic [(2**wididx)-1:0] o_sum,
    output logic                   o_cout
);
    localparam int CW = 2**wididx;

    always_comb begin
        logic [CW-1:0] g;
        logic [CW-1:0] p;
        logic [CW-1:0] p0;
        logic [CW-1:0] c;
        p0   = i_a ^ i_b;
        p    = p0;
        g    = i_a & i_b;
        // Fold carry-in into bit 0 so the prefix tree yields true carries.
        g[0] = g[0] | (p0[0] & i_cin);
        for (int l = 0; l < wididx; l++) begin
            // Descending order keeps g/p[i-d] at the previous level's value.
            for (int i = CW - 1; i >= (1 << l); i--) begin
                g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                p[i] = p[i] & p[i - (1 << l)];
            end
        end
        c[0] = i_cin;
        for (int i = 1; i < CW; i++) begin
            c[i] = g[i-1];
        end
        o_sum  = p0 ^ c;
        o_cout = g[CW-1];
    end

endmodule

// File: rtl/ksa_seq_adder.sv
// Multi-cycle W-bit add/subtract: one chunk per cycle through a shared
// Kogge-Stone adder, LSB chunk first, carry chained through a register.
module ksa_seq_adder
    import ksa_seq_pkg::*;
#(
    parameter int WIDIDX = 3,
    parameter int NWORDS = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NWORDS*(2**WIDIDX)-1:0]      in_a,
    input  logic [NWORDS*(2**WIDIDX)-1:0]      in_b,
    input  logic                               in_sub,
    input  logic                               in_cin,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NWORDS*(2**WIDIDX)-1:0]      out_sum,
    output logic                               out_cout,
    output logic                               out_ovf,
    output logic                               busy
);
    localparam int CW = 2**WIDIDX;
    localparam int W  = NWORDS * CW;
    localparam int IW = idx_w(NWORDS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a_sh;
    logic [W-1:0]    r_b_sh;
    logic [W-1:0]    r_sum_sh;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            r_cout;
    logic            r_ovf;
    logic [CW-1:0]   w_sum;
    logic            w_cout;
    logic            w_accept;
    logic            w_last;
    logic            w_msb_cin;

    KSA #(.wididx(WIDIDX)) u_ksa (
        .i_a    (r_a_sh[CW-1:0]),
        .i_b    (r_b_sh[CW-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_state == RUN) && (r_idx == IW'(NWORDS - 1));
    // Carry into the sign bit, recovered from the sum bit and its operands.
    assign w_msb_cin = w_sum[CW-1] ^ r_a_sh[CW-1] ^ r_b_sh[CW-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = in_valid ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= in_a;
            r_b_sh  <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub ? ~in_cin : in_cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum_sh <= (r_sum_sh >> CW) | (W'(w_sum) << (W - CW));
            r_carry  <= w_cout;
            r_a_sh   <= r_a_sh >> CW;
            r_b_sh   <= r_b_sh >> CW;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= w_cout ^ w_msb_cin;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign out_sum  = r_sum_sh;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_ksa_seq_adder.sv
// Bench for ksa_seq_adder (WIDIDX=3, NWORDS=4): directed corner cases plus
// randomized operations against an integer-arithmetic reference.
module tb_ksa_seq_adder;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_sub;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    ksa_seq_adder #(.WIDIDX(3), .NWORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Plain integer arithmetic: unsigned result for sum/carry, signed for overflow.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, output logic [31:0] s, output logic co,
                         output logic ov);
        longint ua, ub, uc, sa, sb, r, sr;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        uc = longint'({63'd0, cin});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r  = ua - ub - uc;
            sr = sa - sb - uc;
            co = (r >= 0);
        end else begin
            r  = ua + ub + uc;
            sr = sa + sb + uc;
            co = (r >= 64'sd4294967296);
        end
        s  = r[31:0];
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic scramble_inputs();
        in_a   = $urandom;
        in_b   = $urandom;
        in_sub = 1'($urandom_range(0, 1));
        in_cin = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin, input int hold);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        model(a, b, sub, cin, es, ec, eo);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, 64'(out_sum), 64'(es));
        chk({tag, "_cout"}, 64'(out_cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            scramble_inputs();
            chk({tag, "_hold"}, {29'd0, out_valid, in_ready, out_cout, out_sum},
                {29'd0, 1'b1, 1'b0, ec, es});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          lat;
        int          stale;
        logic [31:0] hs;
        logic        hc, ho;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_state", {59'd0, out_valid, busy, in_ready, out_cout, out_ovf},
            {59'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        chk("rst_sum", 64'(out_sum), 64'd0);

        run_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op("ripple_all", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op("sub_5_7",    32'h00000005, 32'h00000007, 1'b1, 1'b0, 0);
        run_op("sub_7_5_b",  32'h00000007, 32'h00000005, 1'b1, 1'b1, 0);
        run_op("ovf_pos",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op("ovf_neg",    32'h80000000, 32'h00000001, 1'b1, 1'b0, 0);
        chk("ovf_neg_sum_direct", 64'(out_sum), 64'h7FFFFFFF);

        // Backpressure for three cycles, then handoff with a same-cycle accept.
        model(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, hs, hc, ho);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h12345678;
        in_b      = 32'h9ABCDEF0;
        in_sub    = 1'b0;
        in_cin    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            scramble_inputs();
            #1;
            chk("bp_hold", {30'd0, out_valid, in_ready, out_ovf, out_cout, out_sum},
                {30'd0, 1'b1, 1'b0, ho, hc, hs});
            @(posedge clk);
            #1;
        end
        chk("bp_final_sum", 64'(out_sum), 64'(hs));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'd1;
        in_b      = 32'd2;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        chk("b2b_running", {62'd0, out_valid, busy}, {62'd0, 1'b0, 1'b1});
        wait_valid(lat);
        chk("b2b_latency", 64'(lat), 64'd4);
        chk("b2b_sum", 64'(out_sum), 64'd3);
        @(posedge clk);
        #1;

        // Reset while the third chunk is being processed.
        in_valid = 1'b1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h01234567;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_state", {61'd0, out_valid, busy, in_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
        chk("midrst_sum", 64'(out_sum), 64'd0);
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        chk("midrst_no_stale", 64'(stale), 64'd0);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (t % 6 == 0) ra = 32'h80000000;
            if (t % 6 == 1) rb = 32'hFFFFFFFF;
            run_op($sformatf("rand%0d", t), ra, rb, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
